// File: rtl/key_scan_pkg.sv
// key_scan_pkg: shared types and constants for the keypad scan controller.
package key_scan_pkg;
  localparam int KEY_N = 10;
  localparam int CODE_W = 4;
  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_REL} state_t;
  typedef struct packed {
    logic              rel;
    logic [CODE_W-1:0] code;
  } evt_t;
endpackage

// File: rtl/key_prio_enc.sv
// key_prio_enc: active-low 10->4 priority encoder; highest-numbered low bit wins.
module key_prio_enc
  import key_scan_pkg::*;
(
  input  logic [KEY_N-1:0]  i_s_n,
  output logic              o_any,
  output logic [CODE_W-1:0] o_code
);
  assign o_any = ~&i_s_n;
  always_comb begin
    o_code = '0;
    for (int i = 0; i < KEY_N; i++) if (!i_s_n[i]) o_code = CODE_W'(i);
  end
endmodule

// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: synchronises and debounces keypad lines, queueing press/release
// events in a small FIFO and driving the live held-key code.
module key_scan_ctrl
  import key_scan_pkg::*;
#(
  parameter int DB_CYCLES    = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter bit EMIT_RELEASE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_N-1:0] S_n,
  output logic [3:0]       L,
  output logic             GS,
  output logic             evt_valid,
  output logic [3:0]       evt_code,
  output logic             evt_rel,
  input  logic             evt_ready,
  output logic             ovf,
  input  logic             ovf_clr
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [KEY_N-1:0]  r_s_in, r_s_meta, r_s_sync;
  logic              w_any, w_match, w_last, w_push, w_push_rel, w_held_nx;
  logic [CODE_W-1:0] w_code, r_cap, w_cap_nx, r_l;
  logic [CW-1:0]     r_cnt, w_cnt_nx;
  state_t            r_state, w_state_nx;
  logic              r_gs, r_ovf;
  evt_t              r_mem [FIFO_DEPTH];
  evt_t              w_evt;
  logic [AW-1:0]     r_wp, r_rp;
  logic [AW:0]       r_fcnt;
  logic              w_full, w_pop, w_wr, w_ovf_set;
  // Input register followed by a two-flop synchroniser; idles at all-released.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s_in   <= '1;
      r_s_meta <= '1;
      r_s_sync <= '1;
    end else begin
      r_s_in   <= S_n;
      r_s_meta <= r_s_in;
      r_s_sync <= r_s_meta;
    end
  key_prio_enc u_enc (.i_s_n(r_s_sync), .o_any(w_any), .o_code(w_code));
  assign w_match = w_any && (w_code == r_cap);
  assign w_last  = r_cnt == CW'(DB_CYCLES - 1);
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_cap_nx   = r_cap;
    w_push     = 1'b0;
    w_push_rel = 1'b0;
    case (r_state)
      IDLE:
        if (w_any) begin
          w_cap_nx   = w_code;
          w_cnt_nx   = '0;
          w_state_nx = DB_PRESS;
        end
      DB_PRESS:
        if (!w_match) w_state_nx = IDLE;
        else if (w_last) begin
          w_state_nx = PRESSED;
          w_push     = 1'b1;
        end else w_cnt_nx = r_cnt + CW'(1);
      PRESSED:
        if (!w_match) begin
          w_state_nx = DB_REL;
          w_cnt_nx   = '0;
        end
      DB_REL:
        if (w_match) w_state_nx = PRESSED;
        else if (w_last) begin
          w_state_nx = IDLE;
          w_push     = EMIT_RELEASE;
          w_push_rel = 1'b1;
        end else w_cnt_nx = r_cnt + CW'(1);
    endcase
  end
  // L/GS are registered from the next state so they align with the press event.
  assign w_held_nx = (w_state_nx == PRESSED) || (w_state_nx == DB_REL);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cap   <= '0;
      r_l     <= '0;
      r_gs    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_cap   <= w_cap_nx;
      r_l     <= w_held_nx ? w_cap_nx : '0;
      r_gs    <= w_held_nx;
    end
  assign w_evt     = {w_push_rel, r_cap};
  assign w_full    = r_fcnt == (AW + 1)'(FIFO_DEPTH);
  assign w_pop     = evt_valid & evt_ready;
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= w_evt;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_fcnt <= r_fcnt + (AW + 1)'(w_wr) - (AW + 1)'(w_pop);
      r_ovf  <= w_ovf_set | (r_ovf & ~ovf_clr);
    end
  assign evt_valid = r_fcnt != '0;
  assign evt_code  = r_mem[r_rp].code;
  assign evt_rel   = r_mem[r_rp].rel;
  assign L         = r_l;
  assign GS        = r_gs;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_key_scan_ctrl.sv
// tb_key_scan_ctrl: directed scenario tests for key_scan_ctrl with default parameters.
module tb_key_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] S_n = 10'h3FF;
  logic [3:0] L, evt_code;
  logic       GS, evt_valid, evt_rel, ovf;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  int         n_pass = 0;
  int         n_tot = 0;
  key_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .S_n(S_n), .L(L), .GS(GS),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_rel(evt_rel),
    .evt_ready(evt_ready), .ovf(ovf), .ovf_clr(ovf_clr)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pop1();
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
  endtask
  task automatic test_reset();
    #2 rst_n = 1'b0;
    tick(2);
    n_tot++; if ({L, GS} !== 5'h0) $display("FAIL rst_lgs got=%h exp=00", {L, GS}); else n_pass++;
    n_tot++; if ({evt_valid, evt_rel, evt_code} !== 6'h0) $display("FAIL rst_evt got=%h exp=00", {evt_valid, evt_rel, evt_code}); else n_pass++;
    n_tot++; if (ovf !== 1'b0) $display("FAIL rst_ovf got=%b exp=0", ovf); else n_pass++;
    rst_n = 1'b1;
    tick(3);
  endtask
  task automatic test_clean_press();
    S_n = 10'h3DF;
    tick(7);
    n_tot++; if ({evt_valid, GS} !== 2'b00) $display("FAIL cp_early got=%b exp=00", {evt_valid, GS}); else n_pass++;
    tick(1);
    n_tot++; if ({evt_valid, evt_rel, evt_code} !== 6'b1_0_0101) $display("FAIL cp_press got=%b exp=100101", {evt_valid, evt_rel, evt_code}); else n_pass++;
    n_tot++; if ({L, GS} !== 5'b0101_1) $display("FAIL cp_lgs got=%b exp=01011", {L, GS}); else n_pass++;
    pop1();
    n_tot++; if (evt_valid !== 1'b0) $display("FAIL cp_pop got=%b exp=0", evt_valid); else n_pass++;
    tick(11);
    S_n = 10'h3FF;
    tick(7);
    n_tot++; if ({evt_valid, GS} !== 2'b01) $display("FAIL cp_dbrel got=%b exp=01", {evt_valid, GS}); else n_pass++;
    tick(1);
    n_tot++; if ({evt_valid, evt_rel, evt_code} !== 6'b1_1_0101) $display("FAIL cp_rel got=%b exp=110101", {evt_valid, evt_rel, evt_code}); else n_pass++;
    n_tot++; if ({L, GS} !== 5'h0) $display("FAIL cp_lgs_off got=%b exp=00000", {L, GS}); else n_pass++;
    pop1();
    tick(3);
  endtask
  task automatic test_bounce();
    S_n = 10'h3F7;
    tick(2);
    S_n = 10'h3FF;
    tick(1);
    S_n = 10'h3F7;
    tick(7);
    n_tot++; if (evt_valid !== 1'b0) $display("FAIL bn_none got=%b exp=0", evt_valid); else n_pass++;
    tick(1);
    n_tot++; if ({evt_valid, evt_rel, evt_code} !== 6'b1_0_0011) $display("FAIL bn_press got=%b exp=100011", {evt_valid, evt_rel, evt_code}); else n_pass++;
    pop1();
    tick(5);
    n_tot++; if (evt_valid !== 1'b0) $display("FAIL bn_once got=%b exp=0", evt_valid); else n_pass++;
    S_n = 10'h3FF;
    tick(8);
    n_tot++; if ({evt_valid, evt_rel, evt_code} !== 6'b1_1_0011) $display("FAIL bn_rel got=%b exp=110011", {evt_valid, evt_rel, evt_code}); else n_pass++;
    pop1();
    tick(3);
  endtask
  task automatic test_two_keys();
    S_n = 10'h2FB;
    tick(8);
    n_tot++; if ({evt_valid, evt_rel, evt_code} !== 6'b1_0_1000) $display("FAIL tk_press8 got=%b exp=101000", {evt_valid, evt_rel, evt_code}); else n_pass++;
    pop1();
    n_tot++; if (evt_valid !== 1'b0) $display("FAIL tk_only8 got=%b exp=0", evt_valid); else n_pass++;
    tick(3);
    S_n = 10'h3FB;
    tick(8);
    n_tot++; if ({evt_valid, evt_rel, evt_code} !== 6'b1_1_1000) $display("FAIL tk_rel8 got=%b exp=111000", {evt_valid, evt_rel, evt_code}); else n_pass++;
    n_tot++; if ({L, GS} !== 5'h0) $display("FAIL tk_gap_lgs got=%b exp=00000", {L, GS}); else n_pass++;
    pop1();
    tick(4);
    n_tot++; if ({evt_valid, evt_rel, evt_code} !== 6'b1_0_0010) $display("FAIL tk_press2 got=%b exp=100010", {evt_valid, evt_rel, evt_code}); else n_pass++;
    n_tot++; if ({L, GS} !== 5'b0010_1) $display("FAIL tk_lgs2 got=%b exp=00101", {L, GS}); else n_pass++;
    pop1();
    S_n = 10'h3FF;
    tick(8);
    n_tot++; if ({evt_valid, evt_rel, evt_code} !== 6'b1_1_0010) $display("FAIL tk_rel2 got=%b exp=110010", {evt_valid, evt_rel, evt_code}); else n_pass++;
    pop1();
    tick(3);
  endtask
  task automatic test_overflow();
    logic [4:0] exp_q [4];
    exp_q[0] = 5'b0_0001; exp_q[1] = 5'b1_0001; exp_q[2] = 5'b0_0100; exp_q[3] = 5'b1_0100;
    S_n = 10'h3FD; tick(10);
    S_n = 10'h3FF; tick(10);
    S_n = 10'h3EF; tick(10);
    S_n = 10'h3FF; tick(10);
    n_tot++; if ({evt_valid, ovf} !== 2'b10) $display("FAIL of_full4 got=%b exp=10", {evt_valid, ovf}); else n_pass++;
    S_n = 10'h37F; tick(10);
    n_tot++; if (ovf !== 1'b1) $display("FAIL of_set got=%b exp=1", ovf); else n_pass++;
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tot++; if ({evt_rel, evt_code} !== exp_q[i] || evt_valid !== 1'b1) $display("FAIL of_drain%0d got=%b/%b exp=1/%b", i, evt_valid, {evt_rel, evt_code}, exp_q[i]); else n_pass++;
      tick(1);
    end
    evt_ready = 1'b0;
    n_tot++; if ({evt_valid, ovf} !== 2'b01) $display("FAIL of_empty got=%b exp=01", {evt_valid, ovf}); else n_pass++;
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    n_tot++; if (ovf !== 1'b0) $display("FAIL of_clr got=%b exp=0", ovf); else n_pass++;
    S_n = 10'h3FF; tick(10);
    n_tot++; if ({evt_valid, evt_rel, evt_code} !== 6'b1_1_0111) $display("FAIL of_rel7 got=%b exp=110111", {evt_valid, evt_rel, evt_code}); else n_pass++;
    pop1();
    tick(2);
  endtask
  task automatic test_back_to_back();
    logic [4:0] exp_q [4];
    exp_q[0] = 5'b1_0001; exp_q[1] = 5'b0_0100; exp_q[2] = 5'b1_0100; exp_q[3] = 5'b0_0110;
    S_n = 10'h3FD; tick(10);
    S_n = 10'h3FF; tick(10);
    S_n = 10'h3EF; tick(10);
    S_n = 10'h3FF; tick(10);
    S_n = 10'h3BF;
    tick(7);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    n_tot++; if ({evt_valid, ovf} !== 2'b10) $display("FAIL bb_noovf got=%b exp=10", {evt_valid, ovf}); else n_pass++;
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tot++; if ({evt_rel, evt_code} !== exp_q[i] || evt_valid !== 1'b1) $display("FAIL bb_drain%0d got=%b/%b exp=1/%b", i, evt_valid, {evt_rel, evt_code}, exp_q[i]); else n_pass++;
      tick(1);
    end
    evt_ready = 1'b0;
    n_tot++; if (evt_valid !== 1'b0) $display("FAIL bb_count4 got=%b exp=0", evt_valid); else n_pass++;
    S_n = 10'h3FF; tick(10);
    pop1();
    tick(2);
  endtask
  task automatic test_reset_mid();
    S_n = 10'h3FD; tick(10);
    S_n = 10'h3FF; tick(10);
    S_n = 10'h1FF; tick(8);
    pop1();
    S_n = 10'h3F7;
    tick(5);
    n_tot++; if ({evt_valid, L, GS} !== 6'b1_1001_1) $display("FAIL rm_pre got=%b exp=110011", {evt_valid, L, GS}); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_tot++; if ({evt_valid, evt_rel, evt_code, L, GS, ovf} !== 12'h0) $display("FAIL rm_async got=%h exp=000", {evt_valid, evt_rel, evt_code, L, GS, ovf}); else n_pass++;
    tick(2);
    rst_n = 1'b1;
    tick(7);
    n_tot++; if (evt_valid !== 1'b0) $display("FAIL rm_early got=%b exp=0", evt_valid); else n_pass++;
    tick(1);
    n_tot++; if ({evt_valid, evt_rel, evt_code} !== 6'b1_0_0011) $display("FAIL rm_fresh got=%b exp=100011", {evt_valid, evt_rel, evt_code}); else n_pass++;
    pop1();
    S_n = 10'h3FF; tick(10);
    pop1();
  endtask
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_two_keys();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
